// File: rtl/skolem_inv_checker.sv
// skolem_inv_checker
// Validates the output x of a Skolem block for the inverse of (x bvudiv s) bvsle t.
// Each accepted {s, t, x} triple is classified as PASS, FAIL or UNSAT.
//   PASS  (01): P(x) holds; witness = x
//   FAIL  (10): P(x) fails, some c satisfies P; witness = first such c
//   UNSAT (11): no c satisfies P; witness = 0
// where P(c) = sle(udiv(c, s), t) and udiv(c, 0) = all ones.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   in_valid/in_ready      input handshake for s_in, t_in, x_in
//   out_valid/out_ready    output handshake for out_res, out_wit
//   pass_cnt/fail_cnt/unsat_cnt  saturating result counters
//
// Configuration macro: SKOLEM_CHK_STATS_EN builds the result counters;
// without it the counter outputs are tied to zero.
module skolem_inv_checker #(
   parameter int unsigned W  = 4,
   parameter int unsigned CW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  s_in,
   input  logic [W-1:0]  t_in,
   input  logic [W-1:0]  x_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [1:0]    out_res,
   output logic [W-1:0]  out_wit,
   output logic [CW-1:0] pass_cnt,
   output logic [CW-1:0] fail_cnt,
   output logic [CW-1:0] unsat_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EVAL   = 2'd1,
      SEARCH = 2'd2,
      RESP   = 2'd3
   } state_e;

   localparam logic [1:0]   RES_NONE  = 2'b00;
   localparam logic [1:0]   RES_PASS  = 2'b01;
   localparam logic [1:0]   RES_FAIL  = 2'b10;
   localparam logic [1:0]   RES_UNSAT = 2'b11;
   localparam logic [W-1:0] ALL_ONES  = {W{1'b1}};

   state_e       state_q, state_d;
   logic [W-1:0] s_q, s_d;
   logic [W-1:0] t_q, t_d;
   logic [W-1:0] x_q, x_d;
   logic [W-1:0] c_q, c_d;
   logic [1:0]   res_q, res_d;
   logic [W-1:0] wit_q, wit_d;
   logic         valid_q, valid_d;

   logic [W-1:0] cand;
   logic [W-1:0] divisor;
   logic [W-1:0] quot;
   logic         pred;
   logic         hs;

   // Predicate on the latched operands; EVAL tests x, SEARCH tests the counter
   always_comb begin
      cand    = (state_q == EVAL) ? x_q : c_q;
      divisor = (s_q == '0) ? W'(1) : s_q;
      quot    = (s_q == '0) ? ALL_ONES : (cand / divisor);
      pred    = ($signed(quot) <= $signed(t_q));
   end

   assign hs = (state_q == RESP) && valid_q && out_ready;

   // Next-state and datapath
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      t_d     = t_q;
      x_d     = x_q;
      c_d     = c_q;
      res_d   = res_q;
      wit_d   = wit_q;
      // out_valid rises one cycle after entering RESP and drops on the handshake edge
      valid_d = (state_q == RESP) && !(valid_q && out_ready);

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               s_d     = s_in;
               t_d     = t_in;
               x_d     = x_in;
               state_d = EVAL;
            end
         end
         EVAL: begin
            if (pred) begin
               res_d   = RES_PASS;
               wit_d   = x_q;
               state_d = RESP;
            end else begin
               c_d     = '0;
               state_d = SEARCH;
            end
         end
         SEARCH: begin
            if (pred) begin
               res_d   = RES_FAIL;
               wit_d   = c_q;
               state_d = RESP;
            end else if (c_q == ALL_ONES) begin
               res_d   = RES_UNSAT;
               wit_d   = '0;
               state_d = RESP;
            end else begin
               c_d = c_q + W'(1);
            end
         end
         RESP: begin
            if (valid_q && out_ready) begin
               res_d   = RES_NONE;
               wit_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         s_q     <= '0;
         t_q     <= '0;
         x_q     <= '0;
         c_q     <= '0;
         res_q   <= RES_NONE;
         wit_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         t_q     <= t_d;
         x_q     <= x_d;
         c_q     <= c_d;
         res_q   <= res_d;
         wit_q   <= wit_d;
         valid_q <= valid_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = valid_q;
   assign out_res   = res_q;
   assign out_wit   = wit_q;

`ifdef SKOLEM_CHK_STATS_EN
   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

   logic [CW-1:0] pass_q, fail_q, unsat_q;

   // Saturating counters bumped on the response handshake
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pass_q  <= '0;
         fail_q  <= '0;
         unsat_q <= '0;
      end else if (hs) begin
         if (res_q == RES_PASS && pass_q != CNT_MAX) begin
            pass_q <= pass_q + CW'(1);
         end
         if (res_q == RES_FAIL && fail_q != CNT_MAX) begin
            fail_q <= fail_q + CW'(1);
         end
         if (res_q == RES_UNSAT && unsat_q != CNT_MAX) begin
            unsat_q <= unsat_q + CW'(1);
         end
      end
   end

   assign pass_cnt  = pass_q;
   assign fail_cnt  = fail_q;
   assign unsat_cnt = unsat_q;
`else
   logic unused_hs;
   assign unused_hs = hs;
   assign pass_cnt  = CW'(0);
   assign fail_cnt  = CW'(0);
   assign unsat_cnt = CW'(0);
`endif

endmodule

// File: tb/tb_skolem_inv_checker.sv
// Scoreboard bench for skolem_inv_checker: the driver pushes expected
// {result, witness, due cycle} entries, the monitor pops them on out_valid.
module tb_skolem_inv_checker;
   localparam int W  = 4;
   localparam int N  = 16;
   localparam int CW = 16;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  s_in, t_in, x_in;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [1:0]    out_res;
   logic [W-1:0]  out_wit;
   logic [CW-1:0] pass_cnt, fail_cnt, unsat_cnt;

   skolem_inv_checker #(.W(W), .CW(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .s_in      (s_in),
      .t_in      (t_in),
      .x_in      (x_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_wit   (out_wit),
      .pass_cnt  (pass_cnt),
      .fail_cnt  (fail_cnt),
      .unsat_cnt (unsat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int res;
      int wit;
      int due;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   passes = 0;
   int   m_pass = 0, m_fail = 0, m_unsat = 0;
   int   stall = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic int sgn(input int v);
      return (v >= N / 2) ? v - N : v;
   endfunction

   // P(c): quotient (all ones when dividing by zero) compared as signed W-bit
   function automatic bit pred(input int c, input int s, input int t);
      int qv;
      qv = (s == 0) ? N - 1 : c / s;
      return sgn(qv) <= sgn(t);
   endfunction

   function automatic int exp_cnt(input int v);
`ifdef SKOLEM_CHK_STATS_EN
      return v;
`else
      return 0 * v;
`endif
   endfunction

   task automatic model(input int s, input int t, input int x,
                        output int res, output int wit, output int lat);
      int first;
      first = -1;
      if (pred(x, s, t)) begin
         res = 1; wit = x; lat = 2;
      end else begin
         for (int c = N - 1; c >= 0; c--) if (pred(c, s, t)) first = c;
         if (first >= 0) begin
            res = 2; wit = first; lat = 3 + first;
         end else begin
            res = 3; wit = 0; lat = 2 + N;
         end
      end
   endtask

   task automatic chk_counters(input string tag);
      chk({tag, "_pass_cnt"},  int'(pass_cnt),  exp_cnt(m_pass));
      chk({tag, "_fail_cnt"},  int'(fail_cnt),  exp_cnt(m_fail));
      chk({tag, "_unsat_cnt"}, int'(unsat_cnt), exp_cnt(m_unsat));
   endtask

   // Monitor: pop on out_valid rise, check stability while stalled, drive out_ready
   logic         prev_v = 1'b0;
   logic [1:0]   h_res;
   logic [W-1:0] h_wit;
   int           h_exp = 0;
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (out_valid) begin
            if (!prev_v) begin
               if (q.size() == 0) begin
                  checks++;
                  $display("FAIL unexpected_response: res %0d wit %0d with empty scoreboard", out_res, out_wit);
                  h_exp = 0;
               end else begin
                  exp_t e;
                  e = q.pop_front();
                  chk("out_res",  int'(out_res), e.res);
                  chk("out_wit",  int'(out_wit), e.wit);
                  chk("latency",  cyc, e.due);
                  h_exp = e.res;
               end
               h_res = out_res;
               h_wit = out_wit;
            end else begin
               chk("hold_res", int'(out_res), int'(h_res));
               chk("hold_wit", int'(out_wit), int'(h_wit));
            end
            chk("in_ready_busy", int'(in_ready), 0);
         end
         chk_counters("run");
      end
      prev_v = out_valid;
      if (stall > 0 && out_valid) begin
         out_ready = 1'b0;
         stall--;
      end else begin
         out_ready = ($urandom_range(0, 3) != 0);
      end
      if (rst_n === 1'b1 && out_valid && out_ready) begin
         if (h_exp == 1) m_pass++;
         if (h_exp == 2) m_fail++;
         if (h_exp == 3) m_unsat++;
      end
   end

   task automatic send(input int s, input int t, input int x);
      int n, res, wit, lat;
      exp_t e;
      n = 0;
      @(negedge clk); #1;
      while (!in_ready && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         checks++;
         $display("FAIL in_ready_timeout: in_ready %0d after %0d cycles", in_ready, n);
      end else begin
         model(s, t, x, res, wit, lat);
         e.res = res; e.wit = wit; e.due = cyc + 1 + lat;
         q.push_back(e);
         s_in = W'(s); t_in = W'(t); x_in = W'(x);
         in_valid = 1'b1;
         @(negedge clk); #1;
         in_valid = 1'b0;
         s_in = W'($urandom); t_in = W'($urandom); x_in = W'($urandom);
      end
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      in_valid = 1'b0;
      s_in = '0; t_in = '0; x_in = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_in_ready",  int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_res",   int'(out_res), 0);
      chk("rst_out_wit",   int'(out_wit), 0);
      chk_counters("rst");
      rst_n = 1'b1;

      // Directed cases
      stall = 3;
      send(1, 7, 0);    // PASS
      send(1, 0, 5);    // FAIL, first candidate hits
      send(1, 8, 3);    // FAIL, only c=8 satisfies
      send(1, 8, 8);    // PASS with witness 8
      send(0, 8, 6);    // UNSAT
      send(0, 15, 2);   // s=0, t=-1: PASS
      send(2, 9, 1);    // UNSAT, quotient never reaches negative range

      // Reset during SEARCH aborts the transaction
      send(0, 8, 1);
      repeat (5) @(negedge clk);
      #1;
      rst_n = 1'b0;
      q.delete();
      m_pass = 0; m_fail = 0; m_unsat = 0;
      @(negedge clk); #1;
      chk("midrst_in_ready",  int'(in_ready), 1);
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_out_res",   int'(out_res), 0);
      chk_counters("midrst");
      rst_n = 1'b1;
      send(1, 8, 3);

      // Randomized triples
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 7) == 0) stall = $urandom_range(1, 4);
         send($urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(0, N - 1));
      end

      n = 0;
      while ((q.size() != 0 || out_valid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0 || out_valid) begin
         checks++;
         $display("FAIL drain_timeout: %0d responses outstanding", q.size());
      end
      repeat (2) @(negedge clk);
      #1;
      chk_counters("final");
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
